// File: rtl/out_port_5_pkg.sv
// Shared definitions for the router output-port stage: flit layout, port indices,
// DIM encodings, FSM states and the saturating hop decrement.
package out_port_5_pkg;

  localparam int FLIT_W = 64;

  localparam int PORT_N  = 4;
  localparam int PORT_S  = 3;
  localparam int PORT_E  = 2;
  localparam int PORT_W  = 1;
  localparam int PORT_PE = 0;

  localparam int DIM_X    = 0;
  localparam int DIM_Y    = 1;
  localparam int DIM_NONE = 2;

  // Bit 63 VC, 62 x-dir, 61 y-dir, 55:52 hop-X, 51:48 hop-Y.
  typedef struct packed {
    logic        vc;
    logic        x_dir;
    logic        y_dir;
    logic [4:0]  rsvd;
    logic [3:0]  hop_x;
    logic [3:0]  hop_y;
    logic [47:0] payload;
  } flit_t;

  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  function automatic logic [3:0] sat_dec4(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

endpackage

// File: rtl/hop_update.sv
// Combinational header rewrite: saturating decrement of the hop field selected by DIM,
// flagging underflow when the field is already zero.
module hop_update
  import out_port_5_pkg::*;
#(
  parameter int DIM = DIM_X
) (
  input  flit_t flit_i,
  output flit_t flit_o,
  output logic  uflow_o
);

  always_comb begin
    flit_o  = flit_i;
    uflow_o = 1'b0;
    if (DIM != DIM_NONE) begin
      if (DIM == DIM_X) begin
        flit_o.hop_x = sat_dec4(flit_i.hop_x);
        uflow_o      = (flit_i.hop_x == 4'd0);
      end else begin
        flit_o.hop_y = sat_dec4(flit_i.hop_y);
        uflow_o      = (flit_i.hop_y == 4'd0);
      end
    end
  end

endmodule

// File: rtl/out_port_5.sv
// Router output port: muxes the granted input flit, rewrites its hop field, holds it in a
// one-entry register and sends it with so/ri; outbuf_full throttles the arbiter.
module out_port_5
  import out_port_5_pkg::*;
#(
  parameter int DIM   = DIM_X,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        gnt,
  input  logic [FLIT_W-1:0] din_n,
  input  logic [FLIT_W-1:0] din_s,
  input  logic [FLIT_W-1:0] din_e,
  input  logic [FLIT_W-1:0] din_w,
  input  logic [FLIT_W-1:0] din_pe,
  output logic [4:0]        pop,
  output logic              outbuf_full,
  output logic              so,
  output logic [FLIT_W-1:0] dout,
  input  logic              ri,
  output logic [CNT_W-1:0]  sent_cnt,
  output logic              err
);

  state_e           state_q;
  flit_t            dout_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic  full, fire, gnt_any, gnt_onehot, accept, uflow, err_set;
  flit_t mux_flit, upd_flit;

  assign full       = (state_q == ST_FULL);
  assign fire       = full & ri;
  assign gnt_any    = |gnt;
  assign gnt_onehot = gnt_any & ((gnt & (gnt - 5'd1)) == 5'd0);
  // Accept into an empty buffer, or into a full one that drains this cycle (bypass).
  assign accept     = gnt_onehot & (~full | fire) & ~reset;

  assign pop         = accept ? gnt : 5'd0;
  assign outbuf_full = gnt_any | (full & ~fire);

  assign mux_flit = ({FLIT_W{gnt[PORT_N]}}  & din_n)
                  | ({FLIT_W{gnt[PORT_S]}}  & din_s)
                  | ({FLIT_W{gnt[PORT_E]}}  & din_e)
                  | ({FLIT_W{gnt[PORT_W]}}  & din_w)
                  | ({FLIT_W{gnt[PORT_PE]}} & din_pe);

  hop_update #(.DIM(DIM)) u_hop_update (
    .flit_i  (mux_flit),
    .flit_o  (upd_flit),
    .uflow_o (uflow)
  );

  // Multi-hot grant, overrun into a non-draining buffer, or hop underflow on capture.
  assign err_set = (gnt_any & ~gnt_onehot) | (gnt_onehot & full & ~fire) | (accept & uflow);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      dout_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (fire) cnt_q <= cnt_q + 1'b1;
      if (err_set) err_q <= 1'b1;
      if (accept) begin
        dout_q  <= upd_flit;
        state_q <= ST_FULL;
      end else if (fire) begin
        state_q <= ST_EMPTY;
      end
    end
  end

  assign so       = full;
  assign dout     = dout_q;
  assign sent_cnt = cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_out_port_5.sv
// Bench for out_port_5: a DIM=X/CNT_W=16 instance and a DIM=Y/CNT_W=4 instance share
// stimulus; both are compared every cycle against a transaction-level model.
module tb_out_port_5;

  logic        clk = 1'b0;
  logic        reset, ri;
  logic [4:0]  gnt;
  logic [63:0] din [5];

  logic [4:0]  pop0, pop1;
  logic        obf0, obf1, so0, so1, err0, err1;
  logic [63:0] dout0, dout1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  always #5 clk = ~clk;

  out_port_5 #(.DIM(0), .CNT_W(16)) u_dut_x (
    .clk(clk), .reset(reset), .gnt(gnt),
    .din_n(din[4]), .din_s(din[3]), .din_e(din[2]), .din_w(din[1]), .din_pe(din[0]),
    .pop(pop0), .outbuf_full(obf0), .so(so0), .dout(dout0), .ri(ri),
    .sent_cnt(cnt0), .err(err0)
  );

  out_port_5 #(.DIM(1), .CNT_W(4)) u_dut_y (
    .clk(clk), .reset(reset), .gnt(gnt),
    .din_n(din[4]), .din_s(din[3]), .din_e(din[2]), .din_w(din[1]), .din_pe(din[0]),
    .pop(pop1), .outbuf_full(obf1), .so(so1), .dout(dout1), .ri(ri),
    .sent_cnt(cnt1), .err(err1)
  );

  int checks = 0;
  int failures = 0;

  // Model state per instance: occupancy of the one-entry buffer, its content, counters.
  bit          m_full [2];
  logic [63:0] m_buf  [2];
  int          m_cnt  [2];
  bit          m_err  [2];

  logic [4:0] last_pop0;
  logic       last_obf0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] hop_model(input logic [63:0] f, input int dim, output bit uf);
    int sh;
    uf = 1'b0;
    if (dim == 2) return f;
    sh = (dim == 0) ? 52 : 48;
    if (((f >> sh) & 64'hF) == 64'd0) begin
      uf = 1'b1;
      return f;
    end
    return f - (64'd1 << sh);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 0; m_buf[i] = '0; m_cnt[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic check_regs();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("so%0d", i),   (i == 0) ? 64'(so0)   : 64'(so1),   64'(m_full[i]));
      chk($sformatf("dout%0d", i), (i == 0) ? dout0      : dout1,      m_buf[i]);
      chk($sformatf("cnt%0d", i),  (i == 0) ? 64'(cnt0)  : 64'(cnt1),  64'(m_cnt[i]));
      chk($sformatf("err%0d", i),  (i == 0) ? 64'(err0)  : 64'(err1),  64'(m_err[i]));
    end
  endtask

  // One clock: drive, compare combinational outputs, clock, compare registered outputs.
  task automatic step(input logic [4:0] g, input logic r, input logic rs);
    bit          oh, fr, acc, uf;
    logic [63:0] sel, nf;
    bit          n_full [2];
    logic [63:0] n_buf  [2];
    int          n_cnt  [2];
    bit          n_err  [2];
    gnt = g; ri = r; reset = rs;
    #1;
    last_pop0 = pop0;
    last_obf0 = obf0;
    oh  = ($countones(g) == 1);
    sel = '0;
    for (int k = 0; k < 5; k++) if (g[k]) sel |= din[k];
    for (int i = 0; i < 2; i++) begin
      fr  = m_full[i] && r;
      acc = oh && (!m_full[i] || fr) && !rs;
      chk($sformatf("pop%0d", i), (i == 0) ? 64'(pop0) : 64'(pop1), acc ? 64'(g) : 64'd0);
      chk($sformatf("obf%0d", i), (i == 0) ? 64'(obf0) : 64'(obf1),
          64'((g != 0) || (m_full[i] && !fr)));
      nf = hop_model(sel, i, uf);
      n_err[i]  = m_err[i] || ($countones(g) > 1) || (oh && m_full[i] && !fr) || (acc && uf);
      n_cnt[i]  = fr ? (m_cnt[i] + 1) % ((i == 0) ? 65536 : 16) : m_cnt[i];
      n_buf[i]  = acc ? nf : m_buf[i];
      n_full[i] = acc ? 1'b1 : (fr ? 1'b0 : m_full[i]);
    end
    @(posedge clk);
    if (rs) model_reset();
    else begin
      for (int i = 0; i < 2; i++) begin
        m_full[i] = n_full[i]; m_buf[i] = n_buf[i]; m_cnt[i] = n_cnt[i]; m_err[i] = n_err[i];
      end
    end
    @(negedge clk);
    check_regs();
  endtask

  task automatic rand_din_nonzero_hops();
    for (int k = 0; k < 5; k++) begin
      din[k] = {$urandom, $urandom};
      din[k][55:52] = 4'($urandom_range(1, 15));
      din[k][51:48] = 4'($urandom_range(1, 15));
    end
  endtask

  typedef struct {
    logic [4:0]  g;
    logic        ri;
    logic        rs;
    logic [4:0]  e_pop;
    logic        e_obf;
    logic        e_so;
    logic [63:0] e_dout;
    int          e_cnt;
    logic        e_err;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int grants, pops, c0;
    logic [4:0] arb_gnt;
    int rr;
    logic [63:0] exp_flit;
    logic [4:0] rg;

    vecs[0] = '{5'b00000, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 64'h0, 0, 1'b0};
    vecs[1] = '{5'b00100, 1'b0, 1'b0, 5'b00100, 1'b1, 1'b1, 64'h0020_0000_0000_0001, 0, 1'b0};
    vecs[2] = '{5'b00000, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 64'h0020_0000_0000_0001, 1, 1'b0};
    vecs[3] = '{5'b00100, 1'b0, 1'b0, 5'b00100, 1'b1, 1'b1, 64'h0020_0000_0000_0001, 1, 1'b0};
    vecs[4] = '{5'b00000, 1'b0, 1'b0, 5'b00000, 1'b1, 1'b1, 64'h0020_0000_0000_0001, 1, 1'b0};
    vecs[5] = '{5'b00001, 1'b0, 1'b0, 5'b00000, 1'b1, 1'b1, 64'h0020_0000_0000_0001, 1, 1'b1};
    vecs[6] = '{5'b00000, 1'b0, 1'b0, 5'b00000, 1'b1, 1'b1, 64'h0020_0000_0000_0001, 1, 1'b1};
    vecs[7] = '{5'b00000, 1'b0, 1'b0, 5'b00000, 1'b1, 1'b1, 64'h0020_0000_0000_0001, 1, 1'b1};
    vecs[8] = '{5'b00000, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 64'h0020_0000_0000_0001, 2, 1'b1};
    vecs[9] = '{5'b00000, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 64'h0020_0000_0000_0001, 2, 1'b1};

    for (int k = 0; k < 5; k++) din[k] = '0;
    din[2] = 64'h0030_0000_0000_0001;
    din[0] = 64'h0010_0000_0000_0002;
    gnt = '0; ri = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();

    // Directed table: first transfer, then back-pressure with an overrun grant.
    for (int v = 0; v < 10; v++) begin
      step(vecs[v].g, vecs[v].ri, vecs[v].rs);
      chk($sformatf("vec%0d_pop", v),  64'(last_pop0), 64'(vecs[v].e_pop));
      chk($sformatf("vec%0d_obf", v),  64'(last_obf0), 64'(vecs[v].e_obf));
      chk($sformatf("vec%0d_so", v),   64'(so0),       64'(vecs[v].e_so));
      chk($sformatf("vec%0d_dout", v), dout0,          vecs[v].e_dout);
      chk($sformatf("vec%0d_cnt", v),  64'(cnt0),      64'(vecs[v].e_cnt));
      chk($sformatf("vec%0d_err", v),  64'(err0),      64'(vecs[v].e_err));
    end

    // Streaming behind a registered round-robin arbiter with all inputs requesting.
    step(5'b0, 1'b0, 1'b1);
    rand_din_nonzero_hops();
    arb_gnt = '0; rr = 0; grants = 0; pops = 0; c0 = int'(cnt0);
    for (int t = 0; t < 21; t++) begin
      step(arb_gnt, 1'b1, 1'b0);
      if (arb_gnt != 0) grants++;
      if (last_pop0 != 0) pops++;
      if (last_obf0) arb_gnt = '0;
      else begin
        arb_gnt = 5'(1 << rr);
        rr = (rr + 1) % 5;
      end
    end
    chk("stream_grants", 64'(grants), 64'd10);
    chk("stream_pops", 64'(pops), 64'd10);
    chk("stream_sent", 64'(int'(cnt0) - c0), 64'd10);
    chk("stream_err", 64'(err0), 64'd0);

    // Bypass: full buffer drains and accepts a new PE flit in the same cycle.
    step(5'b00100, 1'b0, 1'b0);
    exp_flit = din[0] - (64'd1 << 52);
    step(5'b00001, 1'b1, 1'b0);
    chk("bypass_pop", 64'(last_pop0), 64'h1);
    chk("bypass_so", 64'(so0), 64'd1);
    chk("bypass_dout", dout0, exp_flit);
    step(5'b0, 1'b1, 1'b0);

    // Hop-Y underflow on the DIM=Y instance; the DIM=X instance decrements hop-X normally.
    step(5'b0, 1'b0, 1'b1);
    din[4] = 64'h0050_0000_0000_00AB;
    step(5'b10000, 1'b0, 1'b0);
    chk("uflow_dout_y", dout1, 64'h0050_0000_0000_00AB);
    chk("uflow_err_y", 64'(err1), 64'd1);
    chk("uflow_dout_x", dout0, 64'h0040_0000_0000_00AB);
    chk("uflow_err_x", 64'(err0), 64'd0);

    // Multi-hot grant.
    step(5'b0, 1'b0, 1'b1);
    step(5'b10001, 1'b0, 1'b0);
    chk("multihot_pop", 64'(last_pop0), 64'd0);
    chk("multihot_so", 64'(so0), 64'd0);
    chk("multihot_err", 64'(err0), 64'd1);

    // Reset while holding a flit under back-pressure.
    rand_din_nonzero_hops();
    step(5'b00100, 1'b0, 1'b0);
    step(5'b0, 1'b1, 1'b0);
    step(5'b00100, 1'b0, 1'b0);
    step(5'b0, 1'b0, 1'b1);
    chk("rst_so", 64'(so0), 64'd0);
    chk("rst_cnt", 64'(cnt0), 64'd0);
    chk("rst_err", 64'(err0), 64'd0);
    chk("rst_dout", dout0, 64'd0);

    // Counter wrap: 16 transfers on the 4-bit counter.
    for (int t = 0; t < 17; t++) step(5'b00010, 1'b1, 1'b0);
    chk("wrap_cnt_y", 64'(cnt1), 64'd0);
    chk("wrap_cnt_x", 64'(cnt0), 64'd16);
    chk("wrap_err_y", 64'(err1), 64'd0);

    // Randomized traffic against the model.
    step(5'b0, 1'b0, 1'b1);
    for (int t = 0; t < 400; t++) begin
      for (int k = 0; k < 5; k++) din[k] = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0, 1:    rg = 5'b0;
        9:       rg = 5'($urandom_range(0, 31));
        default: rg = 5'(1 << $urandom_range(0, 4));
      endcase
      step(rg, 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
